// File: rtl/pool_relu_stream.sv
// Streaming 2x2 max-pool followed by ReLU over a row-major conv feature map.
// One pooled pixel is emitted per bottom-right window pixel through a one-deep output register.
module pool_relu_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 28,
  parameter int W          = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  sync_err
);

  localparam int RW = (H > 2) ? $clog2(H) : 1;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam int LW = (W > 2) ? $clog2(W / 2) : 1;

  logic [RW-1:0]                row_reg;
  logic [CW-1:0]                col_reg;
  logic signed [DATA_WIDTH-1:0] pair_reg;
  logic signed [DATA_WIDTH-1:0] data_reg;
  logic                         valid_reg;
  logic                         last_reg;
  logic                         err_reg;
  logic signed [DATA_WIDTH-1:0] linebuf [W/2];

  logic                         accept;
  logic                         load;
  logic [RW-1:0]                eff_row;
  logic [CW-1:0]                eff_col;
  logic [RW-1:0]                row_next;
  logic [CW-1:0]                col_next;
  logic [LW-1:0]                lb_idx;
  logic                         row_end;
  logic                         col_end;
  logic signed [DATA_WIDTH-1:0] pix;
  logic signed [DATA_WIDTH-1:0] lb_rd;
  logic signed [DATA_WIDTH-1:0] mx_pair;
  logic signed [DATA_WIDTH-1:0] mx_lb;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign in_ready = !valid_reg || out_ready;

  always_comb begin
    accept   = in_valid && in_ready;
    pix      = in_data;
    // in_first forces the beat to (0,0) whatever the counters say
    eff_row  = in_first ? '0 : row_reg;
    eff_col  = in_first ? '0 : col_reg;
    lb_idx   = LW'(eff_col >> 1);
    lb_rd    = linebuf[lb_idx];
    mx_pair  = smax(pair_reg, pix);
    mx_lb    = smax(lb_rd, pix);
    row_end  = (eff_row == RW'(H - 1));
    col_end  = (eff_col == CW'(W - 1));
    col_next = col_end ? '0 : eff_col + 1'b1;
    row_next = eff_row;
    if (col_end) begin
      row_next = row_end ? '0 : eff_row + 1'b1;
    end
    load     = accept && eff_row[0] && eff_col[0];
  end

  // Line buffer holds the top-row pair maxima; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (reset && accept && !eff_row[0] && eff_col[0]) begin
      linebuf[lb_idx] <= mx_pair;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_reg   <= '0;
      col_reg   <= '0;
      pair_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        if (in_first && (row_reg != '0 || col_reg != '0)) begin
          err_reg <= 1'b1;
        end
        row_reg <= row_next;
        col_reg <= col_next;
        case ({eff_row[0], eff_col[0]})
          2'b00:   pair_reg <= pix;
          2'b10:   pair_reg <= mx_lb;
          default: ;
        endcase
      end
      if (load) begin
        valid_reg <= 1'b1;
        data_reg  <= mx_pair[DATA_WIDTH-1] ? '0 : mx_pair;
        last_reg  <= row_end && col_end;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;
  assign sync_err  = err_reg;

endmodule

// File: tb/tb_pool_relu_stream.sv
// Randomized bench for pool_relu_stream: a frame-array reference model fills an
// expected queue at acceptance time and an independent monitor checks every output.
module tb_pool_relu_stream;
  localparam int DW = 16;
  localparam int H  = 28;
  localparam int W  = 28;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_first = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_last;
  logic                 sync_err;
  logic signed [DW-1:0] out_data;

  pool_relu_stream #(.DATA_WIDTH(DW), .H(H), .W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic ok, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: whole frame stored, window max taken when its bottom-right pixel lands
  typedef struct {
    logic signed [DW-1:0] d;
    logic                 l;
  } exp_t;

  logic signed [DW-1:0] fr [H][W];
  int                   mr = 0;
  int                   mc = 0;
  exp_t                 exp_q[$];
  longint               lat_q[$];
  longint               cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_accept(input logic signed [DW-1:0] d, input logic f);
    int   m;
    exp_t e;
    if (f) begin
      mr = 0;
      mc = 0;
    end
    fr[mr][mc] = d;
    if (mr % 2 == 1 && mc % 2 == 1) begin
      m = fr[mr][mc];
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          if (int'(fr[mr-i][mc-j]) > m) m = fr[mr-i][mc-j];
      e.d = DW'((m < 0) ? 0 : m);
      e.l = (mr == H - 1) && (mc == W - 1);
      exp_q.push_back(e);
      lat_q.push_back(cyc + 1);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  // Driver: inputs change #1 after posedge; acceptance is judged at negedge
  int stalls = 0;

  task automatic send(input logic signed [DW-1:0] d, input logic f);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    for (int t = 0; t < 1000 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) model_accept(d, f);
      else stalls++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 1'b0, 0, 1);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || out_valid) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic send_ramp(input logic with_first);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(DW'(r * W + c), with_first && r == 0 && c == 0);
  endtask

  // Output ready generator: 0 = always ready, 1 = random, 2 = one 10-cycle stall on first valid
  int rmode = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid) begin
            out_ready = 1'b0;
            repeat (10) begin
              @(posedge clk);
              #1;
            end
            out_ready = 1'b1;
            rmode     = 0;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor
  int                   n_out = 0;
  int                   n_last = 0;
  logic signed [DW-1:0] out_hist[$];
  logic                 hold = 1'b0;
  logic signed [DW-1:0] hold_d;
  logic                 hold_l;
  exp_t                 me;

  always @(negedge clk) begin
    if (reset) begin
      if (lat_q.size() > 0 && lat_q[0] == cyc) begin
        chk("latency_valid", out_valid == 1'b1, out_valid, 1);
        void'(lat_q.pop_front());
      end
      if (hold) begin
        chk("hold_data", out_valid && out_data == hold_d, out_data, hold_d);
        chk("hold_last", out_last == hold_l, out_last, hold_l);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready == 1'b0, in_ready, 0);
      if (out_valid && out_ready) begin
        n_out++;
        if (out_last) n_last++;
        out_hist.push_back(out_data);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1'b0, out_data, 0);
        end else begin
          me = exp_q.pop_front();
          chk("out_data", out_data == me.d, out_data, me.d);
          chk("out_last", out_last == me.l, out_last, me.l);
        end
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
    end else begin
      hold = 1'b0;
    end
  end

  function automatic int ramp_ref(input int k);
    return (2 * (k / (W / 2)) + 1) * W + 2 * (k % (W / 2)) + 1;
  endfunction

  task automatic chk_ramp_frame(input string name, input int base);
    int bad;
    bad = 0;
    for (int k = 0; k < (H / 2) * (W / 2); k++)
      if (base + k >= out_hist.size() || int'(out_hist[base + k]) != ramp_ref(k)) bad++;
    chk(name, bad == 0, bad, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    mr = 0;
    mc = 0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("rst_out_data", out_data == '0, out_data, 0);
    chk("rst_out_last", out_last == 1'b0, out_last, 0);
    chk("rst_sync_err", sync_err == 1'b0, sync_err, 0);
    chk("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    reset = 1'b1;
  endtask

  int                   b_out;
  int                   b_last;
  logic signed [DW-1:0] v;

  initial begin
    idle(2);
    do_reset();

    // Ramp frame, always ready: no stalls, exact values, single out_last
    b_out  = n_out;
    b_last = n_last;
    stalls = 0;
    send_ramp(1'b1);
    wait_drain();
    chk("ramp_count", n_out - b_out == 196, n_out - b_out, 196);
    chk("ramp_last_count", n_last - b_last == 1, n_last - b_last, 1);
    chk("ramp_stalls", stalls == 0, stalls, 0);
    chk_ramp_frame("ramp_values", b_out);
    chk("ramp_first_value", out_hist[b_out] == 16'sd29, out_hist[b_out], 29);

    // All-negative frame pools to zero everywhere
    b_out = n_out;
    for (int i = 0; i < H * W; i++) send(-16'sd5, 1'b0);
    wait_drain();
    chk("neg_count", n_out - b_out == 196, n_out - b_out, 196);
    chk("neg_first_zero", out_hist[b_out] == '0, out_hist[b_out], 0);

    // Directed windows in the first two window positions, random elsewhere
    b_out = n_out;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        v = 16'($urandom);
        if (r == 0 && c == 0) v = -16'sd3;
        if (r == 0 && c == 1) v = 16'sd7;
        if (r == 1 && c == 0) v = -16'sd1;
        if (r == 1 && c == 1) v = 16'sd2;
        if (r == 0 && c == 2) v = -16'sd8;
        if (r == 0 && c == 3) v = -16'sd2;
        if (r == 1 && c == 2) v = -16'sd9;
        if (r == 1 && c == 3) v = -16'sd4;
        send(v, 1'b0);
      end
    wait_drain();
    chk("window_pos", out_hist[b_out] == 16'sd7, out_hist[b_out], 7);
    chk("window_neg", out_hist[b_out + 1] == '0, out_hist[b_out + 1], 0);

    // Backpressure: 10-cycle stall on the first output
    b_out  = n_out;
    b_last = n_last;
    rmode  = 2;
    stalls = 0;
    send_ramp(1'b1);
    wait_drain();
    rmode = 0;
    chk("bp_count", n_out - b_out == 196, n_out - b_out, 196);
    chk("bp_stalled", stalls >= 10, stalls, 10);
    chk_ramp_frame("bp_values", b_out);

    // Spurious in_first at (3,5), then a complete frame
    chk("sync_err_clear", sync_err == 1'b0, sync_err, 0);
    for (int i = 0; i < 3 * W + 5; i++) send(16'($urandom), 1'b0);
    b_out = n_out;
    send_ramp(1'b1);
    wait_drain();
    chk("sync_err_set", sync_err == 1'b1, sync_err, 1);
    chk_ramp_frame("resync_values", b_out);
    idle(5);
    chk("sync_err_sticky", sync_err == 1'b1, sync_err, 1);

    // Reset at (15,9), then a ramp frame with no in_first
    for (int i = 0; i < 15 * W + 9; i++) send(16'($urandom), 1'b0);
    wait_drain();
    do_reset();
    b_out = n_out;
    send_ramp(1'b0);
    wait_drain();
    chk("post_reset_count", n_out - b_out == 196, n_out - b_out, 196);
    chk_ramp_frame("post_reset_values", b_out);

    // Two back-to-back frames, random backpressure and idle gaps
    b_out  = n_out;
    b_last = n_last;
    rmode  = 1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < H * W; i++) begin
        if ($urandom_range(0, 9) == 0) idle(1);
        send(DW'(i), f == 0 && i == 0);
      end
    wait_drain();
    rmode = 0;
    chk("b2b_count", n_out - b_out == 392, n_out - b_out, 392);
    chk("b2b_last_count", n_last - b_last == 2, n_last - b_last, 2);
    chk_ramp_frame("b2b_frame0", b_out);
    chk_ramp_frame("b2b_frame1", b_out + 196);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pool_relu_stream.md
POOL_RELU_STREAM -- requirements
Module: pool_relu_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter H, default 28, input feature-map height (conv output rows); SHALL be even.
REQ-003 SHALL have parameter W, default 28, input feature-map width (conv output columns); SHALL be even.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_data/in_first carry a valid conv pixel.
REQ-007 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  conv pixel, row-major order.
REQ-009 SHALL have port in_first  input  1  marks pixel (0,0) of a frame.
REQ-010 SHALL have port out_valid  output  1  out_data holds a pooled pixel.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  ReLU(max of 2x2 window).
REQ-013 SHALL have port out_last  output  1  marks pooled pixel (H/2-1, W/2-1).
REQ-014 SHALL have port sync_err  output  1  sticky: in_first seen at a non-(0,0) position.

Function
REQ-015 SHALL accept an input beat only when in_valid and in_ready are both high.
REQ-016 in_ready SHALL equal (!out_valid || out_ready).
REQ-017 SHALL keep col (0..W-1) and row (0..H-1) counters advanced per accepted beat; col wraps to 0 and increments row at W-1; row wraps to 0 after H-1 (frame end).
REQ-018 An accepted beat with in_first=1 SHALL be treated as position (0,0), regardless of the counters.
REQ-019 If in_first=1 arrives while counters are not at (0,0), sync_err SHALL set and remain set until reset; partial line-buffer contents SHALL be discarded logically (new frame starts at (0,0)).
REQ-020 Even row, even col: SHALL store pixel into pair register.
REQ-021 Even row, odd col: SHALL write signed max(pair, pixel) into line buffer entry col/2 (W/2 entries of DATA_WIDTH).
REQ-022 Odd row, even col: SHALL store signed max(linebuf[col/2], pixel) into pair register.
REQ-023 Odd row, odd col: SHALL compute m = signed max(pair, pixel), load out_data = (m < 0) ? 0 : m, set out_valid=1 on the next edge.
REQ-024 Ties in any max SHALL yield the equal value (no ordering effect); comparisons SHALL be full-width signed, no truncation.
REQ-025 out_last SHALL be 1 with the pooled output produced from input position (H-1, W-1), else 0.
REQ-026 out_valid SHALL clear on an edge where out_valid && out_ready and no new pooled result is loaded; simultaneous drain and load SHALL replace out_data/out_last and keep out_valid=1.
REQ-027 While out_valid && !out_ready, out_data and out_last SHALL stay stable and no input SHALL be accepted.
REQ-028 Latency: pooled pixel SHALL appear one cycle after acceptance of its bottom-right input pixel.
REQ-029 Throughput: with out_ready held high, SHALL accept one pixel per cycle indefinitely with no bubbles, across row and frame boundaries.
REQ-030 Consecutive frames SHALL be processed back-to-back without in_first; counter wrap defines the next frame.

Reset
REQ-031 On an edge with reset=0: out_valid=0, out_data=0, out_last=0, sync_err=0, row=0, col=0, pair register=0; in_ready therefore 1 after reset.
REQ-032 Line-buffer contents need not reset; they SHALL never reach out_data before being rewritten by an even row.
REQ-033 Reset asserted mid-frame SHALL abort the frame; the next accepted pixel is position (0,0).
REQ-034 Reset SHALL take priority over any concurrent handshake.

Verification
REQ-035 Ramp frame: in_data = row*W+col (H=W=28), out_ready=1 -> 196 outputs, output (i,j) = (2i+1)*28+2j+1, out_last only on the 196th, no input stalls.
REQ-036 All-negative frame (every pixel -5) -> 196 outputs all 0; window {-3,7,-1,2} -> 7; window {-8,-2,-9,-4} -> 0.
REQ-037 Backpressure: out_ready low for 10 cycles when first output valid -> in_ready low, out_data held, no beats lost; final output set identical to REQ-035.
REQ-038 Spurious in_first at position (3,5) -> sync_err=1 sticky; following 784 pixels produce a correct full 196-output frame.
REQ-039 Reset (reset=0 one cycle) at position (15,9) -> outputs cleared; next full ramp frame matches REQ-035 exactly.
REQ-040 Two back-to-back ramp frames, random out_ready (50%) -> 392 outputs, two out_last pulses, values match reference model.
